// File: rtl/muldiv_controller_if.sv
// Execute-stage bundle between the issue/decode logic and the mult/div unit.
// The master side issues operations and HI/LO moves.
// The slave side is the mult/div controller, which returns HI/LO, busy and stall.
interface muldiv_controller_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             rd_hilo;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;

    modport master (
        output start, op, src_a, src_b, rd_hilo, wr_hi, wr_lo, wr_data,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  start, op, src_a, src_b, rd_hilo, wr_hi, wr_lo, wr_data,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/muldiv_controller.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// The core works on operand magnitudes: one shift-add or restoring-divide
// iteration per clock. A final FIX cycle applies signs and writes HI/LO.
// Stall holds any instruction that touches HI/LO, or starts another op,
// while an operation is in flight.
module muldiv_controller #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_b,
    muldiv_controller_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // MULT and DIV (op[0]==0) are signed; they run on magnitudes and fix signs at the end.
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.src_a[WIDTH-1];
    assign b_neg     = signed_op & bus.src_b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag     = b_neg ? -bus.src_b : bus.src_b;

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB (held in the low half) is set, then shift right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: trial-subtract the divisor from the shifted remainder.
    // A borrow keeps the old remainder and shifts in a 0 quotient bit.
    // When the remainder's top bit is set, the trial always succeeds,
    // so the dropped bit is never needed.
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign correction and divide-by-zero override applied in the FIX cycle.
    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = div_zero ? a_raw
                               : (neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: launch on start, run WIDTH iterations, then one fix-up cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (count == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and HI/LO: latch operands on launch, iterate, write results or MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc      <= '0;
            operand  <= '0;
            a_raw    <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div   <= bus.op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= bus.op[1] & (bus.src_b == '0);
                        a_raw    <= bus.src_a;
                        operand  <= bus.op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                        count    <= '0;
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= (count == LAST) ? '0 : count + 1'b1;
                end
                FIX: begin
                    hi_q <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller.
// Results are predicted from plain 64-bit arithmetic on the architectural
// operation, and busy length is checked against the fixed latency of WIDTH+1.
module tb_muldiv_controller;
    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    logic clk;
    logic rst_b;
    int   compared;
    int   mismatched;

    muldiv_controller_if #(.WIDTH(WIDTH)) bus ();

    muldiv_controller #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural result {hi, lo} of an operation.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sp;
        int     sa;
        int     sb;
        int     q;
        int     r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op in idle and wait (bounded) for busy to fall; returns busy cycles.
    task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cycles);
        @(negedge clk);
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.rd_hilo = 1'b1;
        #1;
        compared++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_hilo: got hi=%h lo=%h, expected 0/0", bus.hi, bus.lo);
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got busy=%b stall=%b, expected 0/0", bus.busy, bus.stall);
        end
        bus.rd_hilo = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [63:0] want [6];
        int cycles;
        ops = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234};
        bs  = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        want = '{{32'hFFFF_FFFE, 32'h0000_0001}, {32'hFFFF_FFFF, 32'hFFFF_FFF1},
                 {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'd3},
                 {32'h0, 32'h8000_0000}, {32'h1234, 32'hFFFF_FFFF}};
        for (int i = 0; i < 6; i++) begin
            issue_op(ops[i], as[i], bs[i], cycles);
            compared++;
            if (cycles !== LATENCY) begin
                mismatched++;
                $display("[TB] FAIL directed%0d_latency: got %0d busy cycles, expected %0d",
                         i, cycles, LATENCY);
            end
            compared++;
            if ({bus.hi, bus.lo} !== want[i]) begin
                mismatched++;
                $display("[TB] FAIL directed%0d_result: got hi=%h lo=%h, expected hi=%h lo=%h",
                         i, bus.hi, bus.lo, want[i][63:32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'h1111;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_data = 32'h2222;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        compared++;
        if (bus.hi !== 32'h1111 || bus.lo !== 32'h2222) begin
            mismatched++;
            $display("[TB] FAIL idle_write: got hi=%h lo=%h, expected 1111/2222", bus.hi, bus.lo);
        end
        bus.op = 2'b01;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.rd_hilo = 1'b1;
        #1;
        compared++;
        if (bus.stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_rd: got stall=%b, expected 1", bus.stall);
        end
        @(negedge clk);
        bus.rd_hilo = 1'b0;
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'hAAAA;
        bus.start = 1'b1;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        #1;
        compared++;
        if (bus.stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_wr_start: got stall=%b, expected 1", bus.stall);
        end
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.start = 1'b0;
        compared++;
        if (bus.hi !== 32'h1111 || bus.lo !== 32'h2222 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hold_busy: got hi=%h lo=%h busy=%b, expected 1111/2222/1",
                     bus.hi, bus.lo, bus.busy);
        end
        n = 0;
        while (bus.busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        bus.rd_hilo = 1'b1;
        #1;
        compared++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            mismatched++;
            $display("[TB] FAIL stall_final: got busy=%b stall=%b hi=%h lo=%h, expected 0/0/0/2a",
                     bus.busy, bus.stall, bus.hi, bus.lo);
        end
        bus.rd_hilo = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ignored_start: got busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic [63:0] want;
        @(negedge clk);
        bus.op = 2'b01;
        bus.src_a = 32'h0001_0000;
        bus.src_b = 32'h0003_0000;
        bus.start = 1'b1;
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        compared++;
        if (bus.hi !== 32'h3 || bus.lo !== 32'h0 || cycles !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL start_beats_write: got hi=%h lo=%h cycles=%0d, expected 3/0/%0d",
                     bus.hi, bus.lo, cycles, LATENCY);
        end
        issue_op(2'b10, 32'd100, 32'hFFFF_FFF9, cycles);
        want = model(2'b10, 32'd100, 32'hFFFF_FFF9);
        compared++;
        if ({bus.hi, bus.lo} !== want || cycles !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL back_to_back: got hi=%h lo=%h cycles=%0d, expected %h/%h/%0d",
                     bus.hi, bus.lo, cycles, want[63:32], want[31:0], LATENCY);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] want;
        int cycles;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 31);
            want = model(op, a, b);
            issue_op(op, a, b, cycles);
            compared++;
            if ({bus.hi, bus.lo} !== want || cycles !== LATENCY) begin
                mismatched++;
                $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got hi=%h lo=%h cycles=%0d, expected %h/%h/%0d",
                         i, op, a, b, bus.hi, bus.lo, cycles, want[63:32], want[31:0], LATENCY);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'h7777;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.op = 2'b10;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_b = 1'b0;
        #1;
        compared++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_op: got hi=%h lo=%h busy=%b, expected 0/0/0",
                     bus.hi, bus.lo, bus.busy);
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (40) @(negedge clk);
        compared++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_no_late_update: got hi=%h lo=%h busy=%b, expected 0/0/0",
                     bus.hi, bus.lo, bus.busy);
        end
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'h55;
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_wr_stall: got stall=%b, expected 0", bus.stall);
        end
        @(negedge clk);
        bus.wr_lo = 1'b0;
        compared++;
        if (bus.lo !== 32'h55 || bus.hi !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL idle_wr_lo: got hi=%h lo=%h, expected 0/55", bus.hi, bus.lo);
        end
    endtask

    // Test sequence: reset, directed cases, stall behaviour, random ops, mid-op reset.
    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_b       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.rd_hilo = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Sequences a multi-cycle shift-add multiplier and restoring divider for MULT/MULTU/DIV/DIVU.
- Owns the architectural HI/LO registers.
- Generates the stall that holds issue while an operation is in flight and a dependent MFHI/MFLO/MTHI/MTLO or a second mult/div arrives.
- Sits beside the ALU in the execute stage and is driven by the main decoder.

Parameters:
WIDTH, 32, operand width; one iteration per bit.

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
start  input  1  launch op with src_a/src_b (sampled when not busy)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  input  WIDTH  multiplicand / dividend
src_b  input  WIDTH  multiplier / divisor
rd_hilo  input  1  instruction in execute reads HI or LO
wr_hi  input  1  MTHI write request
wr_lo  input  1  MTLO write request
wr_data  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in flight
stall  output  1  hold the requesting instruction

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE, hi=0, lo=0, busy=0, stall=0, counter=0, internal operands cleared.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op, take magnitudes of src_a/src_b for signed ops (raw values for unsigned), clear accumulator, counter=0, go to RUN. busy=1 after E0.
  - start and wr_hi/wr_lo in the same cycle: start wins and the write is dropped.
  - Otherwise, wr_hi/wr_lo update hi/lo at the edge. Both asserted together write both registers.
- RUN:
  - One iteration per edge.
  - Multiply: 2*WIDTH-bit shift-add.
  - Divide: restoring; one quotient bit per edge, remainder in the upper half.
  - Counter increments per iteration. The edge performing the iteration with counter==WIDTH-1 moves to FIX (edges E1..E32 for WIDTH=32).
- FIX (edge E33):
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi (upper/remainder) and lo (lower/quotient), then go to IDLE. busy=0 after E33.
- Latency: busy high for exactly WIDTH+1 cycles; the result is visible in hi/lo the cycle busy falls.
- stall = busy & (start | rd_hilo | wr_hi | wr_lo), combinational. It is 0 whenever busy=0.
- While busy:
  - start, wr_hi and wr_lo are ignored; issue logic relies on stall.
  - hi/lo keep their previous values until FIX.
- Divide by zero (src_b==0, DIV or DIVU): normal latency, result forced to lo=all ones, hi=src_a as issued.
- Signed overflow (DIV of INT_MIN by -1): wraps, giving lo=0x80000000, hi=0.
- All arithmetic is modulo 2^(2*WIDTH); no exceptions are raised.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF:
  - busy high 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divide results:
  - DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 2 -> lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
- Stall and ignored requests during an operation:
  - Start MULTU 6 x 7; on cycle 5 assert rd_hilo, then wr_hi with 0xAAAA and a second start.
  - Required: stall=1 each of those cycles, hi/lo unchanged by them.
  - Final hi=0, lo=42, stall=0 once busy falls.
- Reset and idle writes:
  - Assert rst_b=0 at cycle 10 of a DIV -> hi=lo=0 and busy=0 immediately, with no later update.
  - After release, wr_lo with 0x55 -> lo=0x55 the next cycle, stall=0.
